instr_sequencer: RTL and testbench

//   Instruction-side sequencer for the TB4004 core: the producer of aluOp/aluSubOp and the ALU write strobes.

---
 rtl/instr_sequencer.sv | 137 +++++++++++++
 tb/tb_instr_sequencer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Instruction-side sequencer for the TB4004 core.
// Steps the eight-phase machine cycle, latches the OPR/OPA nibbles from the ROM bus,
// tracks two-word instructions and issues the one-cycle ALU/PC write strobes.
module instr_sequencer #(
  parameter logic [2:0] EXEC_PHASE = 3'd6,
  parameter logic [3:0] RESET_OP   = 4'h0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stepEn,
  input  logic [3:0] romData,
  output logic [2:0] phase,
  output logic       secondWord,
  output logic [3:0] aluOp,
  output logic [3:0] aluSubOp,
  output logic [7:0] dataWord,
  output logic       aluEn,
  output logic       accWe,
  output logic       carryWe,
  output logic       regWe,
  output logic       pcInc,
  output logic       instrDone
);

  typedef enum logic [2:0] {
    A1 = 3'd0,
    A2 = 3'd1,
    A3 = 3'd2,
    M1 = 3'd3,
    M2 = 3'd4,
    X1 = 3'd5,
    X2 = 3'd6,
    X3 = 3'd7
  } phase_t;

  phase_t state;

  logic isTwoWord;
  logic finalCycle;
  logic execFire;
  logic decEn;
  logic decAcc;
  logic decCarry;
  logic decReg;

  assign phase = state;

  // JCN, JUN, JMS and ISZ always fetch a second word; opcode 2 only does for FIM (even OPA).
  assign isTwoWord = (aluOp == 4'h1) || (aluOp == 4'h4) || (aluOp == 4'h5) ||
                     (aluOp == 4'h7) || ((aluOp == 4'h2) && !aluSubOp[0]);

  // By X1 the OPR/OPA of the current instruction are already latched, so the decode is valid
  // for the exec and X3 phases of the first-word cycle as well as for the second-word cycle.
  assign finalCycle = secondWord || !isTwoWord;
  assign execFire   = stepEn && finalCycle && (phase == EXEC_PHASE);

  // Phase counter, opcode/operand latches and the second-word flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= A1;
      secondWord <= 1'b0;
      aluOp      <= RESET_OP;
      aluSubOp   <= 4'h0;
      dataWord   <= 8'h00;
    end else if (stepEn) begin
      state <= phase_t'(state + 3'd1);
      case (state)
        M1: begin
          if (secondWord) dataWord[7:4] <= romData;
          else            aluOp         <= romData;
        end
        M2: begin
          if (secondWord) dataWord[3:0] <= romData;
          else            aluSubOp      <= romData;
        end
        X3: begin
          if (secondWord)     secondWord <= 1'b0;
          else if (isTwoWord) secondWord <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Which register-file/ACC/Carry writes the latched instruction needs when it executes.
  always_comb begin
    decEn    = 1'b0;
    decAcc   = 1'b0;
    decCarry = 1'b0;
    decReg   = 1'b0;
    case (aluOp)
      4'h6, 4'h7: begin
        decEn  = 1'b1;
        decReg = 1'b1;
      end
      4'h8, 4'h9: begin
        decEn    = 1'b1;
        decAcc   = 1'b1;
        decCarry = 1'b1;
      end
      4'hA, 4'hC, 4'hD: begin
        decEn  = 1'b1;
        decAcc = 1'b1;
      end
      4'hB: begin
        decEn  = 1'b1;
        decAcc = 1'b1;
        decReg = 1'b1;
      end
      4'hF: begin
        case (aluSubOp)
          4'h1, 4'h3, 4'hA: decCarry = 1'b1;
          4'h0, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, 4'hB: begin
            decEn    = 1'b1;
            decAcc   = 1'b1;
            decCarry = 1'b1;
          end
          4'hC: begin
            decEn  = 1'b1;
            decAcc = 1'b1;
          end
          4'hD: decEn = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign aluEn     = execFire && decEn;
  assign accWe     = execFire && decAcc;
  assign carryWe   = execFire && decCarry;
  assign regWe     = execFire && decReg;
  assign pcInc     = stepEn && (state == A3);
  assign instrDone = stepEn && finalCycle && (state == X3);

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed instruction scenarios followed by
// random instructions with random stalls, checked against an instruction-level model.
module tb_instr_sequencer;

  localparam int EXEC = 6;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       stepEn;
  logic [3:0] romData;
  logic [2:0] phase;
  logic       secondWord;
  logic [3:0] aluOp;
  logic [3:0] aluSubOp;
  logic [7:0] dataWord;
  logic       aluEn;
  logic       accWe;
  logic       carryWe;
  logic       regWe;
  logic       pcInc;
  logic       instrDone;

  int   vectors     = 0;
  int   miscompares = 0;
  bit   randStalls  = 1'b0;

  logic [3:0] prevOp   = 4'h0;
  logic [3:0] prevSub  = 4'h0;
  logic [7:0] prevData = 8'h00;

  logic [25:0] observed;

  instr_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stepEn     (stepEn),
    .romData    (romData),
    .phase      (phase),
    .secondWord (secondWord),
    .aluOp      (aluOp),
    .aluSubOp   (aluSubOp),
    .dataWord   (dataWord),
    .aluEn      (aluEn),
    .accWe      (accWe),
    .carryWe    (carryWe),
    .regWe      (regWe),
    .pcInc      (pcInc),
    .instrDone  (instrDone)
  );

  // Free-running 10-time-unit clock.
  always #5 clk = ~clk;

  assign observed = {phase, secondWord, aluOp, aluSubOp, dataWord,
                     aluEn, accWe, carryWe, regWe, pcInc, instrDone};

  function automatic logic [25:0] packExp(input logic [2:0] ph, input logic sw,
                                          input logic [3:0] op, input logic [3:0] sub,
                                          input logic [7:0] dw, input logic [3:0] str,
                                          input logic pc, input logic done);
    return {ph, sw, op, sub, dw, str, pc, done};
  endfunction

  function automatic bit twoWordInstr(input logic [3:0] opr, input logic [3:0] opa);
    return (opr inside {4'h1, 4'h4, 4'h5, 4'h7}) || (opr == 4'h2 && opa[0] == 1'b0);
  endfunction

  // Instruction table: {aluEn, accWe, carryWe, regWe} raised in the exec phase.
  function automatic logic [3:0] strobeSet(input logic [3:0] opr, input logic [3:0] opa);
    case (opr)
      4'h6, 4'h7:       return 4'b1001;
      4'h8, 4'h9:       return 4'b1110;
      4'hA, 4'hC, 4'hD: return 4'b1100;
      4'hB:             return 4'b1101;
      4'hF: begin
        if (opa inside {4'h1, 4'h3, 4'hA}) return 4'b0010;
        else if (opa <= 4'hB)              return 4'b1110;
        else if (opa == 4'hC)              return 4'b1100;
        else if (opa == 4'hD)              return 4'b1000;
        else                               return 4'b0000;
      end
      default:          return 4'b0000;
    endcase
  endfunction

  task automatic applyStimulus(input logic en, input logic [3:0] rom);
    stepEn  = en;
    romData = rom;
  endtask

  task automatic checkOutput(input string tag, input logic [25:0] exp);
    @(negedge clk);
    vectors++;
    assert (observed === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, exp);
    end
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction word by word; optional stall burst before stallP of the final
  // word, and optional async reset in phase abortAt of the second word.
  task automatic runInstr(input logic [3:0] opr, input logic [3:0] opa,
                          input logic [3:0] hi, input logic [3:0] lo,
                          input int stallP, input int stallN, input int abortAt);
    int          words;
    int          nStall;
    logic [3:0]  str;
    logic [3:0]  expOp;
    logic [3:0]  expSub;
    logic [7:0]  expDw;
    logic [3:0]  rom;
    bit          fin;
    words = twoWordInstr(opr, opa) ? 2 : 1;
    str   = strobeSet(opr, opa);
    for (int w = 0; w < words; w++) begin
      for (int p = 0; p < 8; p++) begin
        fin    = (w == words - 1);
        expOp  = (w == 0 && p < 4) ? prevOp  : opr;
        expSub = (w == 0 && p < 5) ? prevSub : opa;
        if (w == 1 && p == 4)      expDw = {hi, prevData[3:0]};
        else if (w == 1 && p > 4)  expDw = {hi, lo};
        else                       expDw = prevData;
        if (p == stallP && fin)                         nStall = stallN;
        else if (randStalls && $urandom_range(0, 3) == 0) nStall = $urandom_range(1, 2);
        else                                            nStall = 0;
        for (int s = 0; s < nStall; s++) begin
          applyStimulus(1'b0, 4'($urandom));
          checkOutput($sformatf("stall op%h.%h w%0d ph%0d", opr, opa, w, p),
                      packExp(3'(p), w == 1, expOp, expSub, expDw, 4'b0000, 1'b0, 1'b0));
        end
        if (w == 1 && p == abortAt) begin
          applyStimulus(1'b1, 4'($urandom));
          #2;
          rst_n = 1'b0;
          #1;
          vectors++;
          assert (observed === packExp(3'd0, 1'b0, 4'h0, 4'h0, 8'h00, 4'b0000, 1'b0, 1'b0)) else begin
            miscompares++;
            $error("[TB] FAIL abort-reset: observed %h expected %h", observed,
                   packExp(3'd0, 1'b0, 4'h0, 4'h0, 8'h00, 4'b0000, 1'b0, 1'b0));
          end
          stepEn = 1'b0;
          @(posedge clk);
          #1;
          rst_n = 1'b1;
          @(posedge clk);
          #1;
          prevOp   = 4'h0;
          prevSub  = 4'h0;
          prevData = 8'h00;
          return;
        end
        if (p == 3)      rom = (w == 1) ? hi : opr;
        else if (p == 4) rom = (w == 1) ? lo : opa;
        else             rom = 4'($urandom);
        applyStimulus(1'b1, rom);
        checkOutput($sformatf("op%h.%h w%0d ph%0d", opr, opa, w, p),
                    packExp(3'(p), w == 1, expOp, expSub, expDw,
                            (fin && p == EXEC) ? str : 4'b0000,
                            p == 2, fin && p == 7));
      end
    end
    prevOp  = opr;
    prevSub = opa;
    if (words == 2) prevData = {hi, lo};
  endtask

  // Directed scenarios, then random instruction stream.
  initial begin
    logic [3:0] rOpr;
    logic [3:0] rOpa;
    rst_n   = 1'b0;
    stepEn  = 1'b1;
    romData = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    assert (observed === packExp(3'd0, 1'b0, 4'h0, 4'h0, 8'h00, 4'b0000, 1'b0, 1'b0)) else begin
      miscompares++;
      $error("[TB] FAIL reset-state: observed %h expected %h", observed,
             packExp(3'd0, 1'b0, 4'h0, 4'h0, 8'h00, 4'b0000, 1'b0, 1'b0));
    end
    stepEn = 1'b0;
    rst_n  = 1'b1;
    @(posedge clk);
    #1;

    runInstr(4'h0, 4'h0, 4'h0, 4'h0, -1, 0, -1);
    runInstr(4'h0, 4'h0, 4'h0, 4'h0, -1, 0, -1);
    runInstr(4'h8, 4'h3, 4'h0, 4'h0, -1, 0, -1);
    runInstr(4'h4, 4'h1, 4'h2, 4'h3, -1, 0, -1);
    runInstr(4'h2, 4'h4, 4'hA, 4'h5, -1, 0, -1);
    runInstr(4'h2, 4'h5, 4'h0, 4'h0, -1, 0, -1);
    runInstr(4'hF, 4'h3, 4'h0, 4'h0, -1, 0, -1);
    runInstr(4'hF, 4'hE, 4'h0, 4'h0, -1, 0, -1);
    runInstr(4'hD, 4'h7, 4'h0, 4'h0, EXEC, 5, -1);
    runInstr(4'h7, 4'h2, 4'h6, 4'h9, -1, 0, -1);
    runInstr(4'h5, 4'h6, 4'h9, 4'h8, -1, 0, 5);
    runInstr(4'hB, 4'h4, 4'h0, 4'h0, -1, 0, -1);

    randStalls = 1'b1;
    repeat (60) begin
      rOpr = 4'($urandom);
      rOpa = 4'($urandom);
      runInstr(rOpr, rOpa, 4'($urandom), 4'($urandom), -1, 0, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
